// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory between instruction fetch and
//                data accesses, with data priority, flush and bus timeout.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ireq_F,
  input  logic [DATA_WIDTH-1:0] i_iaddr_F,
  input  logic                  i_flush_F,
  output logic [DATA_WIDTH-1:0] o_instr_F,
  output logic                  o_iack_F,
  output logic                  o_stall_F,
  input  logic                  i_dreq_M,
  input  logic                  i_dwe_M,
  input  logic [DATA_WIDTH-1:0] i_daddr_M,
  input  logic [DATA_WIDTH-1:0] i_dwdata_M,
  output logic [DATA_WIDTH-1:0] o_drdata_M,
  output logic                  o_dack_M,
  output logic                  o_stall_M,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ready,
  output logic                  o_bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_tmo_last = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max  = {CNT_WIDTH{1'b1}};

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   flush_q, flush_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]  instr_q, instr_d;
  logic [DATA_WIDTH-1:0]  drdata_q, drdata_d;
  logic                   iack_q, iack_d;
  logic                   dack_q, dack_d;
  logic                   bus_err_q, bus_err_d;

  logic                   w_tmo;
  logic [DATA_WIDTH-1:0]  w_rdata;

  // A timed-out access completes with all-zero read data.
  assign w_rdata = i_mem_ready ? i_mem_rdata : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    instr_d     = instr_q;
    drdata_d    = drdata_q;
    iack_d      = 1'b0;
    dack_d      = 1'b0;
    bus_err_d   = 1'b0;
    w_tmo       = 1'b0;

    case (state_q)
      IDLE: begin
        // A requester still holding its request during its ack cycle is masked.
        if (i_dreq_M && !dack_q) begin
          state_d     = DACC;
          mem_req_d   = 1'b1;
          mem_we_d    = i_dwe_M;
          mem_addr_d  = i_daddr_M;
          mem_wdata_d = i_dwdata_M;
          cnt_d       = '0;
        end else if (i_ireq_F && !iack_q) begin
          state_d     = IACC;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_iaddr_F;
          mem_wdata_d = '0;
          cnt_d       = '0;
          flush_d     = 1'b0;
        end
      end

      DACC, IACC: begin
        w_tmo = !i_mem_ready && (cnt_q >= c_tmo_last);
        if (i_mem_ready || w_tmo) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = '0;
          flush_d   = 1'b0;
          bus_err_d = w_tmo;
          if (state_q == DACC) begin
            dack_d = 1'b1;
            if (!mem_we_q) drdata_d = w_rdata;
          end else if (!(flush_q || i_flush_F)) begin
            iack_d  = 1'b1;
            instr_d = w_rdata;
          end
        end else begin
          if (cnt_q != c_cnt_max) cnt_d = cnt_q + CNT_WIDTH'(1);
          if (state_q == IACC && i_flush_F) flush_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      instr_q     <= '0;
      drdata_q    <= '0;
      iack_q      <= 1'b0;
      dack_q      <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      instr_q     <= instr_d;
      drdata_q    <= drdata_d;
      iack_q      <= iack_d;
      dack_q      <= dack_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_instr_F   = instr_q;
  assign o_drdata_M  = drdata_q;
  assign o_iack_F    = iack_q;
  assign o_dack_M    = dack_q;
  assign o_bus_err   = bus_err_q;
  assign o_stall_F   = i_ireq_F & ~iack_q;
  assign o_stall_M   = i_dreq_M & ~dack_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Scoreboard bench for mem_port_arbiter with a latency-modelled
//                memory, directed scenarios and randomized concurrent traffic.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int DW  = 32;
  localparam int TMO = 15;

  logic          clk;
  logic          rst;
  logic          i_ireq_F, i_flush_F, i_dreq_M, i_dwe_M, i_mem_ready;
  logic [DW-1:0] i_iaddr_F, i_daddr_M, i_dwdata_M, i_mem_rdata;
  logic [DW-1:0] o_instr_F, o_drdata_M, o_mem_addr, o_mem_wdata;
  logic          o_iack_F, o_stall_F, o_dack_M, o_stall_M;
  logic          o_mem_req, o_mem_we, o_bus_err;

  mem_port_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TMO), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .i_ireq_F(i_ireq_F), .i_iaddr_F(i_iaddr_F), .i_flush_F(i_flush_F),
    .o_instr_F(o_instr_F), .o_iack_F(o_iack_F), .o_stall_F(o_stall_F),
    .i_dreq_M(i_dreq_M), .i_dwe_M(i_dwe_M), .i_daddr_M(i_daddr_M),
    .i_dwdata_M(i_dwdata_M), .o_drdata_M(o_drdata_M), .o_dack_M(o_dack_M),
    .o_stall_M(o_stall_M), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready), .o_bus_err(o_bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [DW-1:0] data;
    bit            load;
    bit            err;
  } exp_t;

  exp_t          ifq[$];
  exp_t          dq[$];
  int            vectors     = 0;
  int            miscompares = 0;
  int            force_lat   = -1;
  logic [DW-1:0] exp_instr   = '0;
  logic [DW-1:0] exp_drdata  = '0;
  logic [DW-1:0] bus_mem [logic [DW-1:0]];
  logic [DW-1:0] ref_mem [logic [DW-1:0]];

  function automatic logic [DW-1:0] hash(input logic [DW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Access latency in cycles of ready=0; TMO or more means the memory never answers.
  function automatic int lat_of(input logic [DW-1:0] a);
    return int'(((a >> 2) * 32'd5 + 32'd3) % 32'd20);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [DW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : hash(a);
  endfunction

  function automatic logic [DW-1:0] bus_rd(input logic [DW-1:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : hash(a);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: counts ready=0 cycles from the first cycle of o_mem_req.
  initial begin : memory
    int cnt;
    int lat;
    bit active;
    active      = 0;
    cnt         = 0;
    lat         = 0;
    i_mem_ready = 1'b0;
    i_mem_rdata = '0;
    forever begin
      tick();
      i_mem_ready = 1'b0;
      i_mem_rdata = $urandom;
      if (!o_mem_req) begin
        active = 0;
      end else begin
        if (!active) begin
          active = 1;
          cnt    = 0;
          lat    = (force_lat >= 0) ? force_lat : lat_of(o_mem_addr);
        end else begin
          cnt++;
        end
        if (cnt == lat && lat < TMO) begin
          i_mem_ready = 1'b1;
          i_mem_rdata = bus_rd(o_mem_addr);
          if (o_mem_we) bus_mem[o_mem_addr] = o_mem_wdata;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_instr  = '0;
        exp_drdata = '0;
      end else begin
        check("stall_F", {31'b0, o_stall_F}, {31'b0, i_ireq_F & ~o_iack_F});
        check("stall_M", {31'b0, o_stall_M}, {31'b0, i_dreq_M & ~o_dack_M});
        if (o_iack_F && o_dack_M) fail("both_acks");
        if (o_bus_err && !o_iack_F && !o_dack_M) fail("bus_err_without_ack");
        if (o_iack_F) begin
          if (ifq.size() == 0) fail("unexpected_iack");
          else begin
            e = ifq.pop_front();
            check("instr", o_instr_F, e.data);
            check("iack_bus_err", {31'b0, o_bus_err}, {31'b0, e.err});
            exp_instr = e.data;
          end
        end
        if (o_dack_M) begin
          if (dq.size() == 0) fail("unexpected_dack");
          else begin
            e = dq.pop_front();
            if (e.load) begin
              check("load_data", o_drdata_M, e.data);
              exp_drdata = e.data;
            end else begin
              check("store_keeps_drdata", o_drdata_M, exp_drdata);
            end
            check("dack_bus_err", {31'b0, o_bus_err}, {31'b0, e.err});
          end
        end
      end
    end
  end

  task automatic do_fetch(input logic [DW-1:0] a);
    exp_t e;
    bit   got;
    e.load = 1;
    e.err  = (lat_of(a) >= TMO);
    e.data = e.err ? '0 : ref_rd(a);
    tick();
    ifq.push_back(e);
    i_ireq_F  = 1'b1;
    i_iaddr_F = a;
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = o_iack_F;
    end
    if (!got) fail("fetch_ack_wait");
    tick();
    i_ireq_F = 1'b0;
  endtask

  task automatic do_data(input logic [DW-1:0] a, input bit we, input logic [DW-1:0] wd);
    exp_t e;
    bit   got;
    e.load = !we;
    e.err  = (lat_of(a) >= TMO);
    e.data = e.err ? '0 : ref_rd(a);
    if (we && !e.err) ref_mem[a] = wd;
    tick();
    dq.push_back(e);
    i_dreq_M   = 1'b1;
    i_dwe_M    = we;
    i_daddr_M  = a;
    i_dwdata_M = wd;
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = o_dack_M;
    end
    if (!got) fail("data_ack_wait");
    tick();
    i_dreq_M = 1'b0;
    i_dwe_M  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, {31'b0, o_mem_req}, '0);
    check({tag, "_mem_we"}, {31'b0, o_mem_we}, '0);
    check({tag, "_mem_addr"}, o_mem_addr, '0);
    check({tag, "_mem_wdata"}, o_mem_wdata, '0);
    check({tag, "_instr"}, o_instr_F, '0);
    check({tag, "_drdata"}, o_drdata_M, '0);
    check({tag, "_iack"}, {31'b0, o_iack_F}, '0);
    check({tag, "_dack"}, {31'b0, o_dack_M}, '0);
    check({tag, "_bus_err"}, {31'b0, o_bus_err}, '0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    exp_t e;
    rst = 1'b0;
    i_ireq_F = 0; i_iaddr_F = '0; i_flush_F = 0;
    i_dreq_M = 0; i_dwe_M = 0; i_daddr_M = '0; i_dwdata_M = '0;
    bus_mem[32'h10]  = 32'h0051_0093;
    ref_mem[32'h10]  = 32'h0051_0093;
    bus_mem[32'h200] = 32'h1234_5678;
    ref_mem[32'h200] = 32'h1234_5678;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    tick();
    rst = 1'b1;
    tick();

    // Fetch with ready tied high: grant next cycle, ack the one after.
    force_lat = 0;
    tick();
    e.data = 32'h0051_0093; e.load = 1; e.err = 0;
    ifq.push_back(e);
    i_ireq_F = 1; i_iaddr_F = 32'h10;
    @(negedge clk);
    check("f_c0_stall", {31'b0, o_stall_F}, 1);
    check("f_c0_req", {31'b0, o_mem_req}, 0);
    tick(); @(negedge clk);
    check("f_c1_req", {31'b0, o_mem_req}, 1);
    check("f_c1_addr", o_mem_addr, 32'h10);
    check("f_c1_we", {31'b0, o_mem_we}, 0);
    check("f_c1_stall", {31'b0, o_stall_F}, 1);
    tick(); @(negedge clk);
    check("f_c2_iack", {31'b0, o_iack_F}, 1);
    check("f_c2_instr", o_instr_F, 32'h0051_0093);
    tick();
    i_ireq_F = 0;

    // Simultaneous fetch and store: store first, fetch after the store ack.
    tick();
    e.data = '0; e.load = 0; e.err = 0;
    dq.push_back(e);
    e.data = ref_rd(32'h20); e.load = 1; e.err = 0;
    ifq.push_back(e);
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    i_ireq_F = 1; i_iaddr_F = 32'h20;
    i_dreq_M = 1; i_dwe_M = 1; i_daddr_M = 32'h100; i_dwdata_M = 32'hDEAD_BEEF;
    tick(); @(negedge clk);
    check("s_c1_we", {31'b0, o_mem_we}, 1);
    check("s_c1_addr", o_mem_addr, 32'h100);
    check("s_c1_wdata", o_mem_wdata, 32'hDEAD_BEEF);
    tick(); @(negedge clk);
    check("s_c2_dack", {31'b0, o_dack_M}, 1);
    check("s_c2_iack", {31'b0, o_iack_F}, 0);
    tick();
    i_dreq_M = 0; i_dwe_M = 0;
    @(negedge clk);
    check("s_c3_req", {31'b0, o_mem_req}, 1);
    check("s_c3_addr", o_mem_addr, 32'h20);
    check("s_c3_we", {31'b0, o_mem_we}, 0);
    tick(); @(negedge clk);
    check("s_c4_iack", {31'b0, o_iack_F}, 1);
    tick();
    i_ireq_F = 0;

    // Load with three wait cycles.
    force_lat = 3;
    tick();
    e.data = 32'h1234_5678; e.load = 1; e.err = 0;
    dq.push_back(e);
    i_dreq_M = 1; i_dwe_M = 0; i_daddr_M = 32'h200;
    for (int c = 1; c <= 4; c++) begin
      tick(); @(negedge clk);
      check("l_wait_req", {31'b0, o_mem_req}, 1);
      check("l_wait_addr", o_mem_addr, 32'h200);
      check("l_wait_dack", {31'b0, o_dack_M}, 0);
      check("l_wait_stall", {31'b0, o_stall_M}, 1);
    end
    tick(); @(negedge clk);
    check("l_ack", {31'b0, o_dack_M}, 1);
    check("l_ack_data", o_drdata_M, 32'h1234_5678);
    check("l_ack_stall", {31'b0, o_stall_M}, 0);
    tick();
    i_dreq_M = 0;
    @(negedge clk);
    check("l_ack_one_cycle", {31'b0, o_dack_M}, 0);
    check("l_data_held", o_drdata_M, 32'h1234_5678);

    // Flushed fetch is dropped, then a new fetch is served.
    force_lat = 2;
    tick();
    i_ireq_F = 1; i_iaddr_F = 32'h30;
    tick();
    tick();
    i_flush_F = 1;
    tick();
    i_flush_F = 0;
    tick();
    force_lat = 0;
    e.data = ref_rd(32'h40); e.load = 1; e.err = 0;
    ifq.push_back(e);
    i_iaddr_F = 32'h40;
    @(negedge clk);
    check("fl_no_iack", {31'b0, o_iack_F}, 0);
    check("fl_instr_kept", o_instr_F, exp_instr);
    tick(); @(negedge clk);
    check("fl_new_addr", o_mem_addr, 32'h40);
    tick(); @(negedge clk);
    check("fl_new_iack", {31'b0, o_iack_F}, 1);
    tick();
    i_ireq_F = 0;

    // Memory never answers: bus error after TMO cycles of request.
    force_lat = 255;
    tick();
    e.data = '0; e.load = 1; e.err = 1;
    dq.push_back(e);
    i_dreq_M = 1; i_dwe_M = 0; i_daddr_M = 32'h300;
    for (int c = 1; c <= TMO; c++) begin
      tick(); @(negedge clk);
      check("t_wait_req", {31'b0, o_mem_req}, 1);
      check("t_wait_err", {31'b0, o_bus_err}, 0);
    end
    tick(); @(negedge clk);
    check("t_err", {31'b0, o_bus_err}, 1);
    check("t_dack", {31'b0, o_dack_M}, 1);
    check("t_data", o_drdata_M, '0);
    check("t_req_low", {31'b0, o_mem_req}, 0);
    tick();
    i_dreq_M = 0;
    @(negedge clk);
    check("t_err_one_cycle", {31'b0, o_bus_err}, 0);

    // Asynchronous reset in the middle of an access.
    tick();
    i_ireq_F = 1; i_iaddr_F = 32'h50;
    tick(); @(negedge clk);
    check("r_req_before", {31'b0, o_mem_req}, 1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    i_ireq_F = 0;
    tick();
    tick();
    rst = 1'b1;
    force_lat = -1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("r_no_iack", {31'b0, o_iack_F}, 0);
      tick();
    end
    do_fetch(32'h54);

    // Randomized concurrent traffic.
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          do_fetch(32'(4 * $urandom_range(0, 63)));
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          do_data(32'h1000 + 32'(4 * $urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
    join

    repeat (5) @(negedge clk);
    check("ifq_drained", 32'(ifq.size()), '0);
    check("dq_drained", 32'(dq.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
